// File: rtl/afifo_wr_burst_gen_pkg.sv
// Shared types for the async FIFO write-side burst engine and pattern generators.
package afifo_wr_burst_gen_pkg;

   typedef enum logic [1:0] {
      AFIFO_MODE_INC,
      AFIFO_MODE_CONST,
      AFIFO_MODE_LFSR,
      AFIFO_MODE_WALK1
   } afifo_mode_e;

   typedef enum logic [1:0] {
      WGEN_IDLE,
      WGEN_WRITE,
      WGEN_GAP,
      WGEN_FIN
   } afifo_wgen_state_e;

   localparam logic [31:0] AFIFO_LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/afifo_wr_burst_gen_if.sv
// Command, FIFO write port and status bundle of the write-side burst engine.
interface afifo_wr_burst_gen_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned GAP_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [1:0]            cmd_mode;
   logic [GAP_WIDTH-1:0]  cmd_gap;
   logic                  abort;
   logic                  wfull;
   logic                  winc;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic [CNT_WIDTH-1:0]  wr_cnt;
   logic [CNT_WIDTH-1:0]  stall_cnt;

   modport master (
      output cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_gap, abort, wfull,
      input  cmd_ready, winc, wdata, busy, done, aborted, wr_cnt, stall_cnt
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_gap, abort, wfull,
      output cmd_ready, winc, wdata, busy, done, aborted, wr_cnt, stall_cnt
   );
endinterface

// File: rtl/afifo_wr_burst_gen_pattern_next.sv
// Next data value for each burst pattern; shared by writer and future read-side checker.
module afifo_pattern_next
   import afifo_wr_burst_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] LFSR_TAPS  = AFIFO_LFSR_TAPS_32
) (
   input  afifo_mode_e           mode_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] next_o
);
   localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(LFSR_TAPS);

   always_comb begin
      next_o = data_i;
      unique case (mode_i)
         AFIFO_MODE_INC:   next_o = data_i + DATA_WIDTH'(1);
         AFIFO_MODE_CONST: next_o = data_i;
         AFIFO_MODE_LFSR:  next_o = (data_i >> 1) ^ (data_i[0] ? TAPS : '0);
         AFIFO_MODE_WALK1: next_o = {data_i[DATA_WIDTH-2:0], data_i[DATA_WIDTH-1]};
         default:          next_o = data_i;
      endcase
   end
endmodule

// File: rtl/afifo_wr_burst_gen.sv
// Write-clock burst engine: turns burst commands into winc/wdata without overflowing the FIFO.
module afifo_wr_burst_gen
   import afifo_wr_burst_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned GAP_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter logic [31:0] LFSR_TAPS  = AFIFO_LFSR_TAPS_32
) (
   input logic                 wclk,
   input logic                 wrst,
   afifo_wr_burst_gen_if.slave bus
);
   afifo_wgen_state_e     state_q, state_d;
   afifo_mode_e           mode_q, mode_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [GAP_WIDTH-1:0]  gap_cfg_q, gap_cfg_d;
   logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  aborted_q, aborted_d;
   logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [DATA_WIDTH-1:0] wdata_next;
   logic [DATA_WIDTH-1:0] start_val;
   afifo_mode_e           cmd_mode;
   logic                  winc;

   afifo_pattern_next #(
      .DATA_WIDTH (DATA_WIDTH),
      .LFSR_TAPS  (LFSR_TAPS)
   ) u_pattern_next (
      .mode_i (mode_q),
      .data_i (wdata_q),
      .next_o (wdata_next)
   );

   assign cmd_mode = afifo_mode_e'(bus.cmd_mode);
   // Write enable is combinational on wfull so a full FIFO is never written.
   assign winc = (state_q == WGEN_WRITE) && !bus.wfull;

   always_comb begin
      start_val = bus.cmd_data;
      if ((cmd_mode == AFIFO_MODE_LFSR || cmd_mode == AFIFO_MODE_WALK1) && bus.cmd_data == '0)
         start_val = DATA_WIDTH'(1);
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      remaining_d = remaining_q;
      gap_cfg_d   = gap_cfg_q;
      gap_cnt_d   = gap_cnt_q;
      wdata_d     = wdata_q;
      aborted_d   = aborted_q;
      wr_cnt_d    = wr_cnt_q;
      stall_cnt_d = stall_cnt_q;
      unique case (state_q)
         WGEN_IDLE: begin
            if (bus.cmd_valid) begin
               mode_d      = cmd_mode;
               gap_cfg_d   = bus.cmd_gap;
               remaining_d = bus.cmd_len;
               wdata_d     = start_val;
               aborted_d   = 1'b0;
               state_d     = (bus.cmd_len == '0) ? WGEN_FIN : WGEN_WRITE;
            end
         end
         WGEN_WRITE: begin
            if (winc) begin
               remaining_d = remaining_q - LEN_WIDTH'(1);
               wdata_d     = wdata_next;
               gap_cnt_d   = gap_cfg_q;
               if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) state_d = WGEN_FIN;
               else if (gap_cfg_q != '0)         state_d = WGEN_GAP;
            end else if (stall_cnt_q != '1) begin
               stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
            if (bus.abort) begin
               state_d   = WGEN_FIN;
               aborted_d = 1'b1;
            end
         end
         WGEN_GAP: begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            if (gap_cnt_q == GAP_WIDTH'(1)) state_d = WGEN_WRITE;
            if (bus.abort) begin
               state_d   = WGEN_FIN;
               aborted_d = 1'b1;
            end
         end
         WGEN_FIN: state_d = WGEN_IDLE;
         default:  state_d = WGEN_IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q     <= WGEN_IDLE;
         mode_q      <= AFIFO_MODE_INC;
         remaining_q <= '0;
         gap_cfg_q   <= '0;
         gap_cnt_q   <= '0;
         wdata_q     <= '0;
         aborted_q   <= 1'b0;
         wr_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         remaining_q <= remaining_d;
         gap_cfg_q   <= gap_cfg_d;
         gap_cnt_q   <= gap_cnt_d;
         wdata_q     <= wdata_d;
         aborted_q   <= aborted_d;
         wr_cnt_q    <= wr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.cmd_ready = (state_q == WGEN_IDLE);
   assign bus.busy      = (state_q != WGEN_IDLE);
   assign bus.done      = (state_q == WGEN_FIN);
   assign bus.winc      = winc;
   assign bus.wdata     = wdata_q;
   assign bus.aborted   = aborted_q;
   assign bus.wr_cnt    = wr_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_afifo_wr_burst_gen.sv
// Directed bench for afifo_wr_burst_gen; inputs change and outputs are checked in the clock-low phase.
module tb_afifo_wr_burst_gen;
   import afifo_wr_burst_gen_pkg::*;

   logic wclk = 1'b0;
   logic wrst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 wclk = ~wclk;

   afifo_wr_burst_gen_if #(
      .DATA_WIDTH (32),
      .LEN_WIDTH  (16),
      .GAP_WIDTH  (8),
      .CNT_WIDTH  (32)
   ) bus ();

   afifo_wr_burst_gen #(
      .DATA_WIDTH (32),
      .LEN_WIDTH  (16),
      .GAP_WIDTH  (8),
      .CNT_WIDTH  (32),
      .LFSR_TAPS  (32'h8020_0003)
   ) u_dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to the next low phase and let combinational outputs settle.
   task automatic step();
      @(negedge wclk);
      #1;
   endtask

   // Present a command for one edge; returns in the first cycle after acceptance.
   task automatic issue(input logic [31:0] data, input logic [15:0] len,
                        input afifo_mode_e mode, input logic [7:0] gap);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = data;
      bus.cmd_len   = len;
      bus.cmd_mode  = mode;
      bus.cmd_gap   = gap;
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 32'hDEAD_BEEF;
      bus.cmd_len   = 16'd7;
   endtask

   initial begin
      logic [31:0] inc_exp [4];
      logic [31:0] walk_exp [4];
      logic        gap_pat [7];
      inc_exp  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      walk_exp = '{32'h1, 32'h2, 32'h4, 32'h8};
      gap_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.cmd_len   = '0;
      bus.cmd_mode  = '0;
      bus.cmd_gap   = '0;
      bus.abort     = 1'b0;
      bus.wfull     = 1'b0;
      step();
      step();
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst_winc",      64'(bus.winc),      64'd0);
      check("rst_busy",      64'(bus.busy),      64'd0);
      check("rst_done",      64'(bus.done),      64'd0);
      check("rst_aborted",   64'(bus.aborted),   64'd0);
      check("rst_wdata",     64'(bus.wdata),     64'd0);
      check("rst_wr_cnt",    64'(bus.wr_cnt),    64'd0);
      check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
      wrst = 1'b0;
      step();

      // INC burst wrapping through zero, back-to-back writes.
      issue(32'hFFFF_FFFE, 16'd4, AFIFO_MODE_INC, 8'd0);
      for (int i = 0; i < 4; i++) begin
         check("inc_winc",  64'(bus.winc),  64'd1);
         check("inc_wdata", 64'(bus.wdata), 64'(inc_exp[i]));
         check("inc_ready", 64'(bus.cmd_ready), 64'd0);
         step();
      end
      check("inc_done",      64'(bus.done), 64'd1);
      check("inc_done_winc", 64'(bus.winc), 64'd0);
      check("inc_done_rdy",  64'(bus.cmd_ready), 64'd0);
      step();
      check("inc_done_pulse", 64'(bus.done),      64'd0);
      check("inc_idle_rdy",   64'(bus.cmd_ready), 64'd1);
      check("inc_wr_cnt",     64'(bus.wr_cnt),    64'd4);

      // Full backpressure for five cycles after the first write.
      issue(32'h0, 16'd3, AFIFO_MODE_INC, 8'd0);
      check("bp_first_winc",  64'(bus.winc),  64'd1);
      check("bp_first_wdata", 64'(bus.wdata), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge wclk);
         bus.wfull = 1'b1;
         #1;
         check("bp_full_winc",  64'(bus.winc),  64'd0);
         check("bp_full_wdata", 64'(bus.wdata), 64'd1);
      end
      @(negedge wclk);
      bus.wfull = 1'b0;
      #1;
      check("bp_w1_winc",  64'(bus.winc),  64'd1);
      check("bp_w1_wdata", 64'(bus.wdata), 64'd1);
      step();
      check("bp_w2_winc",  64'(bus.winc),  64'd1);
      check("bp_w2_wdata", 64'(bus.wdata), 64'd2);
      step();
      check("bp_done",      64'(bus.done),      64'd1);
      check("bp_stall_cnt", 64'(bus.stall_cnt), 64'd5);
      check("bp_wr_cnt",    64'(bus.wr_cnt),    64'd7);
      step();

      // CONST with a two-cycle gap between writes.
      issue(32'hA5A5_A5A5, 16'd3, AFIFO_MODE_CONST, 8'd2);
      for (int i = 0; i < 7; i++) begin
         check("gap_winc", 64'(bus.winc), 64'(gap_pat[i]));
         if (gap_pat[i]) check("gap_wdata", 64'(bus.wdata), 64'h0000_0000_A5A5_A5A5);
         step();
      end
      check("gap_done",   64'(bus.done),   64'd1);
      check("gap_wr_cnt", 64'(bus.wr_cnt), 64'd10);
      step();

      // LFSR with zero seed.
      issue(32'h0, 16'd2, AFIFO_MODE_LFSR, 8'd0);
      check("lfsr_w0", 64'(bus.wdata), 64'h1);
      check("lfsr_winc0", 64'(bus.winc), 64'd1);
      step();
      check("lfsr_w1", 64'(bus.wdata), 64'h8020_0003);
      step();
      check("lfsr_done", 64'(bus.done), 64'd1);
      step();

      // WALK1 with zero seed.
      issue(32'h0, 16'd4, AFIFO_MODE_WALK1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         check("walk_winc",  64'(bus.winc),  64'd1);
         check("walk_wdata", 64'(bus.wdata), 64'(walk_exp[i]));
         step();
      end
      check("walk_done",   64'(bus.done),   64'd1);
      check("walk_wr_cnt", 64'(bus.wr_cnt), 64'd16);
      step();

      // Abort coinciding with the tenth write.
      issue(32'h0, 16'd100, AFIFO_MODE_INC, 8'd0);
      for (int i = 0; i < 9; i++) step();
      bus.abort = 1'b1;
      #1;
      check("abt_w10_winc",  64'(bus.winc),  64'd1);
      check("abt_w10_wdata", 64'(bus.wdata), 64'd9);
      @(negedge wclk);
      bus.abort = 1'b0;
      #1;
      check("abt_done",    64'(bus.done),    64'd1);
      check("abt_aborted", 64'(bus.aborted), 64'd1);
      check("abt_winc",    64'(bus.winc),    64'd0);
      check("abt_wr_cnt",  64'(bus.wr_cnt),  64'd26);
      step();
      check("abt_idle_winc", 64'(bus.winc),    64'd0);
      check("abt_held",      64'(bus.aborted), 64'd1);
      check("abt_ready",     64'(bus.cmd_ready), 64'd1);

      // Empty burst: done right after acceptance, no write, aborted cleared.
      issue(32'h1234_5678, 16'd0, AFIFO_MODE_INC, 8'd0);
      check("len0_done",    64'(bus.done),    64'd1);
      check("len0_winc",    64'(bus.winc),    64'd0);
      check("len0_aborted", 64'(bus.aborted), 64'd0);
      step();
      check("len0_idle_winc", 64'(bus.winc),   64'd0);
      check("len0_wr_cnt",    64'(bus.wr_cnt), 64'd26);

      // Reset in the middle of a burst.
      issue(32'h0, 16'd10, AFIFO_MODE_INC, 8'd0);
      check("rstw_winc1", 64'(bus.winc), 64'd1);
      step();
      check("rstw_winc2", 64'(bus.winc), 64'd1);
      wrst = 1'b1;
      step();
      wrst = 1'b0;
      check("rstw_winc",   64'(bus.winc),   64'd0);
      check("rstw_done",   64'(bus.done),   64'd0);
      check("rstw_busy",   64'(bus.busy),   64'd0);
      check("rstw_wr_cnt", 64'(bus.wr_cnt), 64'd0);
      step();
      check("rstw_done2",  64'(bus.done),      64'd0);
      check("rstw_ready",  64'(bus.cmd_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
